// File: rtl/ppu_clkmode_sequencer.sv
// Sequences every VCLK_Tx_select change: frame-aligned blank, Tx reset hold, mux switch, settle/lock, release, unblank.
// Define PPU_SEQ_LOCK_TIMEOUT_EN to abandon LineX3 after LOCK_TIMEOUT cycles without PLL lock (sticky pll_fail).
module ppu_clkmode_sequencer #(
    parameter int SETTLE_CYCLES      = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT       = 1048576,
    parameter int UNBLANK_FRAMES     = 2
) (
    input  logic       VCLK,
    input  logic       VRST,
    input  logic [1:0] linemult_req,
    input  logic       USE_VPLL,
    input  logic       pll_locked,
    input  logic       vdata_valid_i,
    input  logic       nVSYNC_i,
    output logic [1:0] VCLK_Tx_select,
    output logic       nVRST_Tx_o,
    output logic       nBLANK_o,
    output logic       busy,
    output logic       pll_fail
);

    localparam int HW = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int LW = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int FW = $clog2(UNBLANK_FRAMES) + 1;

    if (SETTLE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
        LOCK_TIMEOUT < 1 || UNBLANK_FRAMES < 1) begin : g_bad_param
        $error("ppu_clkmode_sequencer: cycle and frame parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE, WAIT_VS, RST_HOLD, SETTLE, WAIT_LOCK, RELEASE, UNBLANK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    req_eff_q, req_eff_d;
    logic          nvrst_q, nvrst_d;
    logic          nblank_q, nblank_d;
    logic          vs_prev_q, vs_prev_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d;
    logic          frame_ev;

`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          pll_fail_q, pll_fail_d;
    assign pll_fail = pll_fail_q;
`else
    assign pll_fail = 1'b0;
`endif

    // Falling edge of vsync, judged only across valid samples.
    assign frame_ev  = vdata_valid_i && !nVSYNC_i && vs_prev_q;
    assign vs_prev_d = vdata_valid_i ? nVSYNC_i : vs_prev_q;

    always_comb begin
        req_eff_d = linemult_req;
        if (linemult_req == 2'b11) begin
            req_eff_d = 2'b01;
        end else if (linemult_req == 2'b10 && (!USE_VPLL || pll_fail)) begin
            req_eff_d = 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        sel_d        = sel_q;
        nvrst_d      = nvrst_q;
        nblank_d     = nblank_q;
        hold_cnt_d   = hold_cnt_q;
        settle_cnt_d = settle_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        frm_cnt_d    = frm_cnt_q;
`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        pll_fail_d   = pll_fail_q;
`endif
        case (state_q)
            IDLE: begin
                nvrst_d  = 1'b1;
                nblank_d = 1'b1;
                if (req_eff_q != sel_q) begin
                    target_d = req_eff_q;
                    state_d  = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (req_eff_q == sel_q) begin
                    state_d = IDLE;
                end else if (frame_ev) begin
                    nblank_d   = 1'b0;
                    nvrst_d    = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = RST_HOLD;
                end
            end
            RST_HOLD: begin
                if (hold_cnt_q == HW'(RST_HOLD_CYCLES - 1)) begin
                    sel_d        = target_q;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else if (hold_cnt_q != HW'(RST_HOLD_CYCLES)) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    lock_cnt_d = '0;
`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                    state_d    = (target_q == 2'b10) ? WAIT_LOCK : RELEASE;
                end else if (settle_cnt_q != SW'(SETTLE_CYCLES)) begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            WAIT_LOCK: begin
                // Losing the PLL path falls back to x2; the reset is still held so the mux may move.
                if (!USE_VPLL) begin
                    target_d     = 2'b01;
                    sel_d        = 2'b01;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else if (pll_locked && lock_cnt_q == LW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
                end else if (tmo_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                    pll_fail_d   = 1'b1;
                    target_d     = 2'b01;
                    sel_d        = 2'b01;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
`endif
                end else begin
                    if (!pll_locked) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q != LW'(LOCK_STABLE_CYCLES)) begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end
`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
                    if (tmo_cnt_q != TW'(LOCK_TIMEOUT)) begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
`endif
                end
            end
            RELEASE: begin
                nvrst_d   = 1'b1;
                frm_cnt_d = '0;
                state_d   = UNBLANK;
            end
            UNBLANK: begin
                if (frame_ev) begin
                    if (frm_cnt_q == FW'(UNBLANK_FRAMES - 1)) begin
                        nblank_d = 1'b1;
                        state_d  = IDLE;
                    end else if (frm_cnt_q != FW'(UNBLANK_FRAMES)) begin
                        frm_cnt_d = frm_cnt_q + FW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset lands in RST_HOLD so power-up runs the full sequence without a vsync.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            state_q      <= RST_HOLD;
            target_q     <= 2'b00;
            sel_q        <= 2'b00;
            req_eff_q    <= 2'b00;
            nvrst_q      <= 1'b0;
            nblank_q     <= 1'b0;
            vs_prev_q    <= 1'b1;
            hold_cnt_q   <= '0;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
            frm_cnt_q    <= '0;
`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            pll_fail_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            sel_q        <= sel_d;
            req_eff_q    <= req_eff_d;
            nvrst_q      <= nvrst_d;
            nblank_q     <= nblank_d;
            vs_prev_q    <= vs_prev_d;
            hold_cnt_q   <= hold_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            frm_cnt_q    <= frm_cnt_d;
`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            pll_fail_q   <= pll_fail_d;
`endif
        end
    end

    assign VCLK_Tx_select = sel_q;
    assign nVRST_Tx_o     = nvrst_q;
    assign nBLANK_o       = nblank_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ppu_clkmode_sequencer.sv
// Directed bench for ppu_clkmode_sequencer: every change of {select, nVRST, nBLANK} is matched against a timed expectation queue.
// Build with +define+PPU_SEQ_LOCK_TIMEOUT_EN to include the lock-timeout scenario.
`timescale 1ns/1ps
module tb_ppu_clkmode_sequencer;
    localparam int RH = 16;
    localparam int ST = 1024;
    localparam int LS = 8;
    localparam int LT = 64;

    logic       VCLK = 1'b0;
    logic       VRST;
    logic [1:0] linemult_req;
    logic       USE_VPLL;
    logic       pll_locked;
    logic       vdata_valid_i;
    logic       nVSYNC_i;
    logic [1:0] VCLK_Tx_select;
    logic       nVRST_Tx_o;
    logic       nBLANK_o;
    logic       busy;
    logic       pll_fail;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic       nvrst;
        logic       nblank;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc      = 0;
    int         n_assert = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    logic [3:0] prev_out = 4'h0;

    ppu_clkmode_sequencer #(
        .SETTLE_CYCLES(ST), .RST_HOLD_CYCLES(RH), .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT(LT), .UNBLANK_FRAMES(2)
    ) dut (
        .VCLK(VCLK), .VRST(VRST), .linemult_req(linemult_req), .USE_VPLL(USE_VPLL),
        .pll_locked(pll_locked), .vdata_valid_i(vdata_valid_i), .nVSYNC_i(nVSYNC_i),
        .VCLK_Tx_select(VCLK_Tx_select), .nVRST_Tx_o(nVRST_Tx_o), .nBLANK_o(nBLANK_o),
        .busy(busy), .pll_fail(pll_fail)
    );

    always #5 VCLK = ~VCLK;
    always @(posedge VCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    always @(negedge VCLK) begin
        logic [3:0] cur;
        exp_t       e;
        cur = {VCLK_Tx_select, nVRST_Tx_o, nBLANK_o};
        if (mon_en && cur !== prev_out) begin
            chk("mon_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mon_cycle", 32'(cyc), 32'(e.cyc));
                chk("mon_outputs", 32'(cur), 32'({e.sel, e.nvrst, e.nblank}));
            end
        end
        prev_out = cur;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge VCLK);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push(input int c, input logic [1:0] s, input logic nv, input logic nb);
        exp_q.push_back('{c, s, nv, nb});
    endtask

    // Frame event lands on the second edge after the call.
    task automatic frame();
        vdata_valid_i = 1'b1; nVSYNC_i = 1'b1; tick(1);
        nVSYNC_i = 1'b0; tick(1);
        vdata_valid_i = 1'b0; nVSYNC_i = 1'b1;
    endtask

    task automatic kick();
        tick(2);
        chk("busy_after_req", 32'(busy), 32'd1);
    endtask

    task automatic start_and_hold(input logic [1:0] old_sel, input logic [1:0] new_sel, output int s);
        tick(20);
        push(cyc + 2, old_sel, 1'b0, 1'b0);
        push(cyc + 2 + RH, new_sel, 1'b0, 1'b0);
        s = cyc + 2 + RH;
        frame();
        chk("blank_at_vsync", 32'(nBLANK_o), 32'd0);
        wait_until(s - 1);
        chk("sel_before_switch", 32'(VCLK_Tx_select), 32'(old_sel));
        wait_until(s);
        chk("sel_switched", 32'(VCLK_Tx_select), 32'(new_sel));
    endtask

    task automatic settle_release(input int s, input logic [1:0] sel);
        push(s + ST + 1, sel, 1'b1, 1'b0);
        wait_until(s + 200);
        frame();
        wait_until(s + ST);
        chk("nvrst_before_release", 32'(nVRST_Tx_o), 32'd0);
        wait_until(s + ST + 1);
        chk("nvrst_release", 32'(nVRST_Tx_o), 32'd1);
    endtask

    task automatic unblank(input logic [1:0] sel);
        frame();
        vdata_valid_i = 1'b1; nVSYNC_i = 1'b1; tick(1);
        vdata_valid_i = 1'b0; nVSYNC_i = 1'b0; tick(3);
        nVSYNC_i = 1'b1; tick(1);
        push(cyc + 2, sel, 1'b1, 1'b1);
        frame();
        chk("unblanked", 32'(nBLANK_o), 32'd1);
        tick(3);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sel", 32'(VCLK_Tx_select), 32'(sel));
    endtask

    initial begin
        int r;
        int s;
        int d;
        VRST = 1'b1; linemult_req = 2'b00; USE_VPLL = 1'b1; pll_locked = 1'b0;
        vdata_valid_i = 1'b0; nVSYNC_i = 1'b1;
        tick(3);
        chk("reset_sel", 32'(VCLK_Tx_select), 32'd0);
        chk("reset_nvrst", 32'(nVRST_Tx_o), 32'd0);
        chk("reset_nblank", 32'(nBLANK_o), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_pll_fail", 32'(pll_fail), 32'd0);
        mon_en = 1'b1;

        // Power-up sequence to x1
        VRST = 1'b0; r = cyc;
        settle_release(r + RH, 2'b00);
        unblank(2'b00);

        // x1 -> x2, then an aborted request
        linemult_req = 2'b01; kick();
        start_and_hold(2'b00, 2'b01, s);
        settle_release(s, 2'b01);
        unblank(2'b01);
        linemult_req = 2'b00; kick();
        linemult_req = 2'b01; tick(2);
        chk("abort_busy", 32'(busy), 32'd0);
        tick(10);
        chk("abort_nblank", 32'(nBLANK_o), 32'd1);
        chk("abort_nvrst", 32'(nVRST_Tx_o), 32'd1);

        // x2 -> x3 with a lock glitch
        linemult_req = 2'b10; USE_VPLL = 1'b1; pll_locked = 1'b0; kick();
        start_and_hold(2'b01, 2'b10, s);
        wait_until(s + ST);
        pll_locked = 1'b1; tick(3);
        pll_locked = 1'b0; tick(1);
        pll_locked = 1'b1; d = cyc;
        push(d + LS + 1, 2'b10, 1'b1, 1'b0);
        tick(LS);
        chk("lock_not_early", 32'(nVRST_Tx_o), 32'd0);
        tick(1);
        chk("lock_release", 32'(nVRST_Tx_o), 32'd1);
        unblank(2'b10);

        // x3 request without PLL falls back to x2
        USE_VPLL = 1'b0; kick();
        start_and_hold(2'b10, 2'b01, s);
        settle_release(s, 2'b01);
        unblank(2'b01);

        // PLL disappears while waiting for lock
        USE_VPLL = 1'b1; pll_locked = 1'b0; kick();
        start_and_hold(2'b01, 2'b10, s);
        wait_until(s + ST + 5);
        USE_VPLL = 1'b0; d = cyc;
        push(d + 1, 2'b01, 1'b0, 1'b0);
        tick(1);
        chk("vpll_drop_sel", 32'(VCLK_Tx_select), 32'd1);
        settle_release(d + 1, 2'b01);
        unblank(2'b01);

        // Reset pulse during SETTLE restarts power-up
        USE_VPLL = 1'b1; kick();
        start_and_hold(2'b01, 2'b10, s);
        wait_until(s + 100);
        VRST = 1'b1; linemult_req = 2'b00;
        push(cyc + 1, 2'b00, 1'b0, 1'b0);
        tick(1);
        chk("midrst_sel", 32'(VCLK_Tx_select), 32'd0);
        chk("midrst_nvrst", 32'(nVRST_Tx_o), 32'd0);
        chk("midrst_nblank", 32'(nBLANK_o), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        VRST = 1'b0; r = cyc;
        settle_release(r + RH, 2'b00);
        unblank(2'b00);

`ifdef PPU_SEQ_LOCK_TIMEOUT_EN
        linemult_req = 2'b10; USE_VPLL = 1'b1; pll_locked = 1'b0; kick();
        start_and_hold(2'b00, 2'b10, s);
        push(s + ST + LT, 2'b01, 1'b0, 1'b0);
        wait_until(s + ST + LT - 1);
        chk("pll_fail_before_timeout", 32'(pll_fail), 32'd0);
        tick(1);
        chk("pll_fail_set", 32'(pll_fail), 32'd1);
        chk("timeout_sel", 32'(VCLK_Tx_select), 32'd1);
        settle_release(s + ST + LT, 2'b01);
        unblank(2'b01);
        tick(20);
        chk("after_fail_sel", 32'(VCLK_Tx_select), 32'd1);
        chk("after_fail_busy", 32'(busy), 32'd0);
        chk("pll_fail_sticky", 32'(pll_fail), 32'd1);
`else
        linemult_req = 2'b10; USE_VPLL = 1'b1; pll_locked = 1'b0; kick();
        start_and_hold(2'b00, 2'b10, s);
        wait_until(s + ST + 200);
        chk("no_timeout_pll_fail", 32'(pll_fail), 32'd0);
        chk("no_timeout_waiting", 32'(nVRST_Tx_o), 32'd0);
        chk("no_timeout_busy", 32'(busy), 32'd1);
        pll_locked = 1'b1; d = cyc;
        push(d + LS + 1, 2'b10, 1'b1, 1'b0);
        tick(LS + 1);
        chk("late_lock_release", 32'(nVRST_Tx_o), 32'd1);
        unblank(2'b10);
`endif

        tick(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
